// File: rtl/mysticm_input_cond.sv
// Input conditioning for the Mystic Marathon williams2 core: debounce,
// opposing-direction cleanup, pause latch and coin pulse shaping.
module mysticm_input_cond #(
    parameter int DEBOUNCE_CYC = 12000,
    parameter int COIN_PULSE   = 600000,
    parameter int COIN_GAP     = 600000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] joy,
    output logic        btn_right,
    output logic        btn_left,
    output logic        btn_down,
    output logic        btn_up,
    output logic        btn_trigger,
    output logic        btn_start_1,
    output logic        btn_start_2,
    output logic        btn_coin,
    output logic        paused,
    output logic        coin_busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int CMAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [DB_W-1:0] DB_END    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0]   PULSE_END = CW'(COIN_PULSE - 1);
    localparam logic [CW-1:0]   GAP_END   = CW'(COIN_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        RELEASE
    } coin_st_e;

    logic [8:0]            raw;
    logic                  unused_hi;

    logic [8:0]            db_q, db_d;
    logic [8:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]            prev_q, prev_d;
    logic                  paused_q, paused_d;
    logic [6:0]            btn_q, btn_d;
    coin_st_e              st_q, st_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  coin_q, coin_d;

    logic                  pause_rise;
    logic                  coin_rise;
    logic                  lr_x;
    logic                  ud_x;

    assign raw       = joy[8:0];
    assign unused_hi = ^joy[15:9];

    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 9; i++) begin
            if (raw[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_END) begin
                db_d[i]     = raw[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Edges are taken on the debounced level, one cycle after it settles.
    assign prev_d     = db_q[8:7];
    assign pause_rise = db_q[8] & ~prev_q[1];
    assign coin_rise  = db_q[7] & ~prev_q[0];
    assign paused_d   = paused_q ^ pause_rise;

    assign lr_x = db_q[0] & db_q[1];
    assign ud_x = db_q[2] & db_q[3];

    always_comb begin
        btn_d    = '0;
        btn_d[0] = db_q[0] & ~lr_x;
        btn_d[1] = db_q[1] & ~lr_x;
        btn_d[2] = db_q[2] & ~ud_x;
        btn_d[3] = db_q[3] & ~ud_x;
        btn_d[4] = db_q[4];
        btn_d[5] = db_q[5];
        btn_d[6] = db_q[6];
        if (paused_q) begin
            btn_d = '0;
        end
    end

    // The coin FSM sees the pre-toggle pause value.
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        coin_d = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (coin_rise && !paused_q) begin
                    st_d   = PULSE;
                    cnt_d  = '0;
                    coin_d = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_END) begin
                    st_d  = GAP;
                    cnt_d = '0;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    coin_d = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_END) begin
                    st_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (!db_q[7]) begin
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            db_q     <= '0;
            db_cnt_q <= '0;
            prev_q   <= '0;
            paused_q <= 1'b0;
            btn_q    <= '0;
            st_q     <= IDLE;
            cnt_q    <= '0;
            coin_q   <= 1'b0;
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            prev_q   <= prev_d;
            paused_q <= paused_d;
            btn_q    <= btn_d;
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            coin_q   <= coin_d;
        end
    end

    assign btn_right   = btn_q[0];
    assign btn_left    = btn_q[1];
    assign btn_down    = btn_q[2];
    assign btn_up      = btn_q[3];
    assign btn_trigger = btn_q[4];
    assign btn_start_1 = btn_q[5];
    assign btn_start_2 = btn_q[6];
    assign btn_coin    = coin_q;
    assign paused      = paused_q;
    assign coin_busy   = (st_q != IDLE);

endmodule

// File: tb/tb_mysticm_input_cond.sv
// Directed bench for mysticm_input_cond with DEBOUNCE_CYC=4,
// COIN_PULSE=8, COIN_GAP=6.
module tb_mysticm_input_cond;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] joy;
    logic        btn_right, btn_left, btn_down, btn_up;
    logic        btn_trigger, btn_start_1, btn_start_2;
    logic        btn_coin, paused, coin_busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    mysticm_input_cond #(
        .DEBOUNCE_CYC(4),
        .COIN_PULSE  (8),
        .COIN_GAP    (6)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .joy        (joy),
        .btn_right  (btn_right),
        .btn_left   (btn_left),
        .btn_down   (btn_down),
        .btn_up     (btn_up),
        .btn_trigger(btn_trigger),
        .btn_start_1(btn_start_1),
        .btn_start_2(btn_start_2),
        .btn_coin   (btn_coin),
        .paused     (paused),
        .coin_busy  (coin_busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] all_out();
        return {btn_right, btn_left, btn_down, btn_up, btn_trigger,
                btn_start_1, btn_start_2, btn_coin, paused, coin_busy};
    endfunction

    // Holds coin for cycles 1..hold of an n-cycle window and measures
    // the btn_coin waveform (first high cycle, high count, rising edges).
    task automatic coin_win(input int n, input int hold, output int first,
                            output int hi, output int rises);
        logic prev;
        first = 0;
        hi    = 0;
        rises = 0;
        prev  = btn_coin;
        for (int i = 1; i <= n; i++) begin
            joy = (i <= hold) ? 16'h0080 : 16'h0000;
            step(1);
            if (btn_coin) begin
                hi++;
                if (first == 0) first = i;
            end
            if (btn_coin && !prev) rises++;
            prev = btn_coin;
        end
    endtask

    initial begin
        int first, hi, rises;
        logic seen;
        logic prev;

        // 1: reset and basic latency
        reset = 1'b1;
        joy   = 16'h01FF;
        step(3);
        chk("reset_outputs", 32'(all_out()), 32'h0);
        reset = 1'b0;
        joy   = 16'h0010;
        step(4);
        chk("trig_lat4", 32'(btn_trigger), 32'h0);
        step(1);
        chk("trig_lat5", 32'(btn_trigger), 32'h1);

        // 2: short glitch is filtered
        joy = 16'h0000;
        step(6);
        chk("trig_release", 32'(btn_trigger), 32'h0);
        seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            joy = (i <= 3) ? 16'h0010 : 16'h0000;
            step(1);
            seen = seen | btn_trigger;
        end
        chk("glitch_filtered", 32'(seen), 32'h0);

        // upper joystick bits have no effect
        joy = 16'hFE00;
        step(6);
        chk("upper_bits_ignored", 32'(all_out()), 32'h0);

        // 3: SOCD
        joy = 16'h0003;
        step(5);
        chk("socd_lr_both", 32'({btn_right, btn_left}), 32'h0);
        joy = 16'h0001;
        step(4);
        chk("socd_r_lat4", 32'({btn_right, btn_left}), 32'h0);
        step(1);
        chk("socd_r_only", 32'({btn_right, btn_left}), 32'h2);
        joy = 16'h000C;
        step(5);
        chk("socd_ud_both", 32'({btn_up, btn_down}), 32'h0);
        joy = 16'h0008;
        step(5);
        chk("socd_u_only", 32'({btn_up, btn_down}), 32'h2);
        joy = 16'h0000;
        step(6);

        // 4: held coin gives one 8-cycle pulse
        coin_win(40, 40, first, hi, rises);
        chk("coin_first", 32'(first), 32'd5);
        chk("coin_width", 32'(hi), 32'd8);
        chk("coin_one_pulse", 32'(rises), 32'd1);
        chk("coin_busy_held", 32'(coin_busy), 32'h1);
        joy = 16'h0000;
        step(4);
        chk("busy_rel4", 32'(coin_busy), 32'h1);
        step(1);
        chk("busy_rel5", 32'(coin_busy), 32'h0);

        // 5: press during GAP is discarded
        hi    = 0;
        rises = 0;
        prev  = btn_coin;
        for (int i = 1; i <= 30; i++) begin
            joy = (i <= 6 || (i >= 13 && i <= 16)) ? 16'h0080 : 16'h0000;
            step(1);
            if (btn_coin) hi++;
            if (btn_coin && !prev) rises++;
            prev = btn_coin;
        end
        chk("gap_press_rises", 32'(rises), 32'd1);
        chk("gap_press_width", 32'(hi), 32'd8);
        chk("gap_press_idle", 32'(coin_busy), 32'h0);
        coin_win(20, 6, first, hi, rises);
        chk("repress_first", 32'(first), 32'd5);
        chk("repress_width", 32'(hi), 32'd8);
        step(2);
        chk("repress_idle", 32'(coin_busy), 32'h0);

        // 6: pause latch
        joy = 16'h0100;
        step(4);
        chk("pause_lat4", 32'(paused), 32'h0);
        step(1);
        chk("pause_set", 32'(paused), 32'h1);
        step(1);
        chk("pause_held_no_retoggle", 32'(paused), 32'h1);
        joy = 16'h0000;
        step(6);
        chk("pause_after_release", 32'(paused), 32'h1);
        joy = 16'h0070;
        step(6);
        chk("paused_mask", 32'({btn_trigger, btn_start_1, btn_start_2}),
            32'h0);
        coin_win(20, 6, first, hi, rises);
        chk("paused_coin_none", 32'(hi), 32'd0);
        chk("paused_coin_idle", 32'(coin_busy), 32'h0);
        joy = 16'h0000;
        step(6);
        joy = 16'h0100;
        step(5);
        chk("pause_clear", 32'(paused), 32'h0);
        joy = 16'h0000;
        step(6);
        joy = 16'h0070;
        step(6);
        chk("unpaused_pass", 32'({btn_trigger, btn_start_1, btn_start_2}),
            32'h7);
        joy = 16'h0000;
        step(6);

        // reset in the middle of a pulse
        coin_win(7, 7, first, hi, rises);
        chk("midpulse_high", 32'(btn_coin), 32'h1);
        reset = 1'b1;
        joy   = 16'h0000;
        step(1);
        chk("midpulse_reset", 32'({btn_coin, coin_busy}), 32'h0);
        reset = 1'b0;
        step(6);
        chk("post_reset_quiet", 32'(all_out()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
